// File: rtl/truth_table_sweeper_if.sv
// Handshake and data bundle between the truth-table sweeper and whatever
// drives it (board I/O or a top-level bench) plus the lab DUT it exercises.
interface truth_table_sweeper_if #(
  parameter int N = 3,
  parameter int M = 1
);
  localparam int TW = M * (2 ** N);

  logic          start;
  logic          loop;
  logic          abort;
  logic [TW-1:0] expect_tt;
  logic [M-1:0]  f_in;
  logic [N-1:0]  vec;
  logic          busy;
  logic          done;
  logic [TW-1:0] tt;
  logic          pass;

  modport master (
    output start, loop, abort, expect_tt, f_in,
    input  vec, busy, done, tt, pass
  );

  modport slave (
    input  start, loop, abort, expect_tt, f_in,
    output vec, busy, done, tt, pass
  );
endinterface

// File: rtl/truth_table_sweeper.sv
// Exhaustive input sweeper: drives all 2^N vectors into a combinational DUT,
// holds each for HOLD clocks, captures the response table and self-checks it.
module truth_table_sweeper #(
  parameter int N    = 3,
  parameter int M    = 1,
  parameter int HOLD = 20
) (
  input  logic                 clk,
  input  logic                 rst,
  truth_table_sweeper_if.slave bus
);
  localparam int              TW        = M * (2 ** N);
  localparam int              HW        = $clog2(HOLD + 1);
  localparam int              ENTRIES   = 2 ** N;
  localparam logic [N-1:0]    LAST_IDX  = N'(ENTRIES - 1);
  localparam logic [HW-1:0]   HOLD_LAST = HW'(HOLD - 1);

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    DONE
  } state_t;

  state_t         state;
  state_t         state_next;
  logic [N-1:0]   idx;
  logic [N-1:0]   idx_next;
  logic [HW-1:0]  hold_cnt;
  logic [HW-1:0]  hold_next;
  logic [TW-1:0]  tt_q;
  logic           pass_q;
  logic           pass_next;
  logic           sample_en;
  logic           tt_match;

  assign tt_match = (tt_q == bus.expect_tt);

  // Abort is evaluated after the sample decision so that an abort landing on
  // the final sample still writes that entry but never reaches DONE.
  always_comb begin
    state_next = state;
    idx_next   = idx;
    hold_next  = hold_cnt;
    pass_next  = pass_q;
    sample_en  = 1'b0;

    unique case (state)
      IDLE: begin
        if (bus.start) begin
          state_next = DRIVE;
          idx_next   = '0;
          hold_next  = '0;
        end
      end

      DRIVE: begin
        if (hold_cnt == HOLD_LAST) begin
          sample_en = 1'b1;
          if (idx == LAST_IDX) begin
            state_next = DONE;
          end else begin
            idx_next  = idx + N'(1);
            hold_next = '0;
          end
        end else begin
          hold_next = hold_cnt + HW'(1);
        end
        if (bus.abort) begin
          state_next = IDLE;
        end
      end

      DONE: begin
        pass_next = tt_match;
        if (bus.loop) begin
          state_next = DRIVE;
          idx_next   = '0;
          hold_next  = '0;
        end else begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      idx      <= '0;
      hold_cnt <= '0;
      tt_q     <= '0;
      pass_q   <= 1'b0;
    end else begin
      state    <= state_next;
      idx      <= idx_next;
      hold_cnt <= hold_next;
      pass_q   <= pass_next;
      for (int i = 0; i < ENTRIES; i++) begin
        if (sample_en && (idx == N'(i))) begin
          tt_q[i*M +: M] <= bus.f_in;
        end
      end
    end
  end

  // During DONE the verdict comes straight from the completed table so it is
  // valid alongside the done pulse; afterwards the registered copy holds it.
  assign bus.busy = (state == DRIVE);
  assign bus.done = (state == DONE);
  assign bus.vec  = (state == DRIVE) ? idx : '0;
  assign bus.tt   = tt_q;
  assign bus.pass = (state == DONE) ? tt_match : pass_q;

endmodule
